filter_regbank_v2: RTL and testbench
====================================

Name: filter_regbank_v2

Overview:
Second-generation configuration/status register bank for the N-channel filter array. It adds:
- shadowed filter configuration with an atomic commit,
- write-1-to-clear interrupt status with a per-channel mask,
- a registered interrupt request output,
- per-channel saturating event counters,
- a registered, acknowledged bus access with an error flag.

It sits between the byte-wide configuration bus and the filter channels.

Parameters:
N, 8, number of filter channels (1..64)
ADDR_W, 8, bus address width; must cover the full map (2N+2S+1 addresses)
CNT_W, 8, event counter width (1..8); readback is zero-extended to 8 bits
Derived constant (not overridable): S = ceil(N/8), the number of status/mask bytes

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
req_i  in  1  access request, one cycle per access
wr_en_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  ADDR_W  byte address
wdata_i  in  8  write data
rdata_o  out  8  read data; valid only while ack_o=1, otherwise 0
ack_o  out  1  access completion pulse
err_o  out  1  out-of-range address pulse; coincides with ack_o
filter_type_o  out  2N  active filter type per channel
window_size_o  out  4N  active window size per channel
wd_rst_o  out  N  active watchdog reset per channel
in_int_i  in  N  per-channel interrupt event pulses
irq_o  out  1  aggregated, masked interrupt request

Behaviour:
- Reset is asynchronous, active-low, on rstn_i; clock is clk_i. All registers and outputs reset to 0.
- Address map:
  - 0..N-1: CTRL_SH[i] (shadow; bits [1:0] type, [5:2] window, [6] int_en, [7] wd_rst)
  - N..N+S-1: INT_STAT[j] (W1C)
  - N+S..N+2S-1: INT_MASK[j] (1 = masked)
  - N+2S..2N+2S-1: EVT_CNT[i] (read-to-clear)
  - 2N+2S: GCTRL (bit0 COMMIT, bit1 CLR_ALL; both self-clearing, always read 0)
  - Addresses above this: out of range.
- Bus timing:
  - ack_o is req_i delayed by 1 cycle; back-to-back requests are allowed.
  - rdata_o is registered and presented in the ack cycle.
  - A write takes effect at the clock edge ending the req cycle.
  - Out of range: write ignored, read returns 0, err_o=1 with ack_o.
- Shadow/active: writes update CTRL_SH only. Writing COMMIT=1 copies every CTRL_SH into CTRL_ACT at the edge ending the req cycle; the filter outputs change the next cycle. The filter outputs are driven only from CTRL_ACT.
- INT_STAT bit i:
  - Set when in_int_i[i]=1 and CTRL_ACT[i].int_en=1.
  - Cleared by writing 1 to that bit; writing 0 has no effect.
  - A set and a clear in the same cycle: set wins.
  - CLR_ALL clears all bits, with the same set-wins rule.
  - Padding bits (i>=N) read 0 and are not writable.
- INT_MASK: plain read/write; padding bits read 0.
- irq_o is registered: OR over (INT_STAT & ~INT_MASK), one cycle after the state changes.
- EVT_CNT[i]:
  - Increments on every in_int_i[i] pulse, regardless of int_en, and saturates at 2^CNT_W-1.
  - A read returns the value and clears the counter.
  - Read-clear and increment in the same cycle: the read returns the old value and the counter becomes 1.
  - Writes are ignored (no err_o).
  - CLR_ALL zeroes all counters; increment-same-cycle gives 1.
- Mid-operation reset: a pending ack and all shadow/active state are dropped immediately.

Decomposition:
- Package filter_regbank_pkg:
  - constants for field bit positions (TYPE_LSB, WIN_LSB, INT_EN_BIT, WD_RST_BIT, COMMIT_BIT, CLR_ALL_BIT);
  - functions returning the base addresses (stat_base(N), mask_base(N), cnt_base(N), gctrl_addr(N)) and num_stat_regs(N).
- Sub-module filter_regbank_chan, instantiated N times. Each instance holds:
  - CTRL_SH and CTRL_ACT,
  - the event counter with saturation and read-clear,
  - the status set input.
- The top level contains address decode, the W1C/mask byte registers, the read mux, the ack/err pipeline and irq_o.

Test Plan:
- Write 0x4D to addr 2 with no commit → filter outputs for ch2 stay 0. Write GCTRL=0x01 → the cycle after commit, type[5:4]=2'b01, win[11:8]=4'b0011, wd_rst[2]=0.
- Enable int_en on ch0 and commit. Pulse in_int_i[0] → INT_STAT0 reads 0x01 and irq_o=1. Write 0x01 to addr N → irq_o=0 two cycles later. Set and W1C in the same cycle → the bit stays 1.
- Set INT_MASK0=0x01 with INT_STAT0 bit0 set → irq_o falls to 0 while INT_STAT0 still reads 0x01.
- With CNT_W=4, pulse ch3 20 times → EVT_CNT3 reads 0x0F and the next read returns 0x00. A pulse coincident with a read → the read returns the old value and the counter then reads 0x01.
- Read addr 2N+2S+1 → ack_o=1, err_o=1, rdata_o=0x00. Write to the same address → no state change.
- Reset asserted mid-access, and two back-to-back reads (addr 0 then N) → no ack after reset; back-to-back reads give ack on consecutive cycles with the correct data in each.

Source files
------------

// File: rtl/filter_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module : filter_regbank_pkg
// Brief  : Shared field positions and address-map helpers for the filter
//          configuration register bank.
//          Address map, in order:
//            CTRL_SH[N] | INT_STAT[S] | INT_MASK[S] | EVT_CNT[N] | GCTRL
//          where S = ceil(N/8).
// Rev    : 2.0 - shadow/active config, W1C status, event counters
// ============================================================================
package filter_regbank_pkg;

    // CTRL byte fields
    localparam int TYPE_LSB    = 0;
    localparam int WIN_LSB     = 2;
    localparam int INT_EN_BIT  = 6;
    localparam int WD_RST_BIT  = 7;

    // GCTRL byte fields
    localparam int COMMIT_BIT  = 0;
    localparam int CLR_ALL_BIT = 1;

    function automatic int unsigned num_stat_regs(input int unsigned n);
        return (n + 32'd7) / 32'd8;
    endfunction

    function automatic int unsigned stat_base(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned mask_base(input int unsigned n);
        return n + num_stat_regs(n);
    endfunction

    function automatic int unsigned cnt_base(input int unsigned n);
        return n + 32'd2 * num_stat_regs(n);
    endfunction

    function automatic int unsigned gctrl_addr(input int unsigned n);
        return 32'd2 * n + 32'd2 * num_stat_regs(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_regbank_v2_chan.sv
`default_nettype none
// ============================================================================
// Module : filter_regbank_chan
// Brief  : Per-channel slice: shadow and active control bytes, saturating
//          read-to-clear event counter, and the status-set request.
// Ports  : clk_i/rstn_i  clock, async active-low reset
//          i_sh_we       write i_wdata into the shadow control byte
//          i_commit      copy shadow into active
//          i_evt         channel interrupt event pulse
//          i_cnt_rd      counter is being read (clears it)
//          i_cnt_clr     global counter clear
//          o_ctrl_sh     shadow byte for readback
//          o_type/o_win/o_wd_rst  active filter configuration
//          o_stat_set    event qualified by the active int_en
//          o_cnt         counter zero-extended to 8 bits
// Rev    : 2.0
// ============================================================================
module filter_regbank_chan
    import filter_regbank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       i_sh_we,
    input  logic [7:0] i_wdata,
    input  logic       i_commit,
    input  logic       i_evt,
    input  logic       i_cnt_rd,
    input  logic       i_cnt_clr,
    output logic [7:0] o_ctrl_sh,
    output logic [1:0] o_type,
    output logic [3:0] o_win,
    output logic       o_wd_rst,
    output logic       o_stat_set,
    output logic [7:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [7:0]       r_sh;
    logic [7:0]       r_act;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sh  <= '0;
            r_act <= '0;
        end else begin
            if (i_sh_we) begin
                r_sh <= i_wdata;
            end
            if (i_commit) begin
                r_act <= r_sh;
            end
        end
    end

    // A clear (read or global) coinciding with an event leaves the counter
    // at 1 so that the event is not lost; the read still returns the old value.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (i_cnt_rd || i_cnt_clr) begin
            r_cnt <= i_evt ? c_CNT_ONE : '0;
        end else if (i_evt && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        o_cnt              = '0;
        o_cnt[CNT_W-1:0]   = r_cnt;
    end

    assign o_ctrl_sh  = r_sh;
    assign o_type     = r_act[TYPE_LSB +: 2];
    assign o_win      = r_act[WIN_LSB +: 4];
    assign o_wd_rst   = r_act[WD_RST_BIT];
    assign o_stat_set = i_evt & r_act[INT_EN_BIT];

endmodule
`default_nettype wire

// File: rtl/filter_regbank_v2.sv
`default_nettype none
// ============================================================================
// Module : filter_regbank_v2
// Brief  : Configuration/status register bank for the N-channel filter
//          array. Byte-wide bus with one-cycle registered ack/err, shadowed
//          per-channel control with atomic commit, W1C interrupt status with
//          mask, registered irq and per-channel event counters.
// Ports  : clk_i, rstn_i            clock, async active-low reset
//          req_i, wr_en_i, addr_i,
//          wdata_i                  access request (one cycle per access)
//          rdata_o, ack_o, err_o    response, one cycle after req_i
//          filter_type_o, window_size_o, wd_rst_o  active channel config
//          in_int_i                 per-channel event pulses
//          irq_o                    OR of unmasked status bits (registered)
// Rev    : 2.0
// ============================================================================
module filter_regbank_v2
    import filter_regbank_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [2*N-1:0]    filter_type_o,
    output logic [4*N-1:0]    window_size_o,
    output logic [N-1:0]      wd_rst_o,
    input  logic [N-1:0]      in_int_i,
    output logic              irq_o
);

    localparam int unsigned c_S          = num_stat_regs(N);
    localparam int unsigned c_STAT_BASE  = stat_base(N);
    localparam int unsigned c_MASK_BASE  = mask_base(N);
    localparam int unsigned c_CNT_BASE   = cnt_base(N);
    localparam int unsigned c_GCTRL_ADDR = gctrl_addr(N);

    logic [31:0]      w_a;
    logic             w_wr;
    logic             w_rd;
    logic             w_oor;
    logic             w_gctrl_wr;
    logic             w_commit;
    logic             w_clr_all;

    logic [N-1:0]     w_sh_we;
    logic [N-1:0]     w_cnt_rd;
    logic [N-1:0]     w_stat_set;
    logic [N-1:0]     w_stat_clr;
    logic [N-1:0]     w_mask_we;
    logic [N-1:0]     w_bit_wd;
    logic [7:0]       w_ctrl_sh [N];
    logic [7:0]       w_cnt     [N];

    logic [8*c_S-1:0] w_stat_pad;
    logic [8*c_S-1:0] w_mask_pad;
    logic [7:0]       w_rdata;

    logic [N-1:0]     r_stat;
    logic [N-1:0]     r_mask;
    logic             r_irq;
    logic             r_ack;
    logic             r_err;
    logic [7:0]       r_rdata;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_a        = 32'(addr_i);
    assign w_wr       = req_i &  wr_en_i;
    assign w_rd       = req_i & ~wr_en_i;
    assign w_oor      = (w_a > c_GCTRL_ADDR);
    assign w_gctrl_wr = w_wr && (w_a == c_GCTRL_ADDR);
    assign w_commit   = w_gctrl_wr & wdata_i[COMMIT_BIT];
    assign w_clr_all  = w_gctrl_wr & wdata_i[CLR_ALL_BIT];

    // ------------------------------------------------------------------
    // Channel slices and per-bit decode of the packed status/mask bytes
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        localparam int unsigned c_BYTE     = gi / 8;
        localparam int unsigned c_CNT_ADDR = c_CNT_BASE + gi;

        assign w_sh_we[gi]    = w_wr && (w_a == 32'(gi));
        assign w_cnt_rd[gi]   = w_rd && (w_a == c_CNT_ADDR);
        assign w_bit_wd[gi]   = wdata_i[gi % 8];
        assign w_stat_clr[gi] = w_clr_all ||
                                (w_wr && (w_a == c_STAT_BASE + c_BYTE) && w_bit_wd[gi]);
        assign w_mask_we[gi]  = w_wr && (w_a == c_MASK_BASE + c_BYTE);

        filter_regbank_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .i_sh_we    (w_sh_we[gi]),
            .i_wdata    (wdata_i),
            .i_commit   (w_commit),
            .i_evt      (in_int_i[gi]),
            .i_cnt_rd   (w_cnt_rd[gi]),
            .i_cnt_clr  (w_clr_all),
            .o_ctrl_sh  (w_ctrl_sh[gi]),
            .o_type     (filter_type_o[2*gi +: 2]),
            .o_win      (window_size_o[4*gi +: 4]),
            .o_wd_rst   (wd_rst_o[gi]),
            .o_stat_set (w_stat_set[gi]),
            .o_cnt      (w_cnt[gi])
        );
    end

    // ------------------------------------------------------------------
    // Status (W1C, set wins) and mask registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_stat <= '0;
            r_mask <= '0;
        end else begin
            r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
            for (int i = 0; i < N; i++) begin
                if (w_mask_we[i]) begin
                    r_mask[i] <= w_bit_wd[i];
                end
            end
        end
    end

    // Padding bits above N are tied to zero in the readback view
    always_comb begin
        w_stat_pad        = '0;
        w_mask_pad        = '0;
        w_stat_pad[N-1:0] = r_stat;
        w_mask_pad[N-1:0] = r_mask;
    end

    // ------------------------------------------------------------------
    // Read mux; GCTRL and out-of-range addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_a == 32'(i)) begin
                w_rdata = w_ctrl_sh[i];
            end
            if (w_a == c_CNT_BASE + 32'(i)) begin
                w_rdata = w_cnt[i];
            end
        end
        for (int j = 0; j < int'(c_S); j++) begin
            if (w_a == c_STAT_BASE + 32'(j)) begin
                w_rdata = w_stat_pad[8*j +: 8];
            end
            if (w_a == c_MASK_BASE + 32'(j)) begin
                w_rdata = w_mask_pad[8*j +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline and interrupt request
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack   <= req_i;
            r_err   <= req_i & w_oor;
            r_rdata <= w_rd ? w_rdata : 8'h00;
            r_irq   <= |(r_stat & ~r_mask);
        end
    end

    assign ack_o   = r_ack;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;
    assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_filter_regbank_v2.sv
`default_nettype none
// ============================================================================
// Module : tb_filter_regbank_v2
// Brief  : Scoreboard bench for filter_regbank_v2 (N=8, CNT_W=4).
//          Map: CTRL 0..7, STAT 8, MASK 9, CNT 10..17, GCTRL 18, OOR >= 19.
// Rev    : 2.0
// ============================================================================
module tb_filter_regbank_v2;

    localparam int N      = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              req_i;
    logic              wr_en_i;
    logic [ADDR_W-1:0] addr_i;
    logic [7:0]        wdata_i;
    logic [7:0]        rdata_o;
    logic              ack_o;
    logic              err_o;
    logic [2*N-1:0]    filter_type_o;
    logic [4*N-1:0]    window_size_o;
    logic [N-1:0]      wd_rst_o;
    logic [N-1:0]      in_int_i;
    logic              irq_o;

    filter_regbank_v2 #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_i         (req_i),
        .wr_en_i       (wr_en_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_o       (rdata_o),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .filter_type_o (filter_type_o),
        .window_size_o (window_size_o),
        .wd_rst_o      (wd_rst_o),
        .in_int_i      (in_int_i),
        .irq_o         (irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_ack    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Issue one bus access (called at posedge+1) and queue its expected response
    task automatic acc(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err, input string nm);
        exp_t e;
        e.rd = exp_rd; e.err = exp_err; e.nm = nm;
        q.push_back(e);
        req_i   = 1'b1;
        wr_en_i = wr;
        addr_i  = a;
        wdata_i = d;
        @(posedge clk_i); #1;
        req_i   = 1'b0;
        wr_en_i = 1'b0;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            in_int_i[ch] = 1'b1;
            @(posedge clk_i); #1;
            in_int_i[ch] = 1'b0;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    // Monitor: compare every ack against the scoreboard head
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (ack_o) begin
                n_ack++;
                if (q.size() == 0) begin
                    chk("unexpected_ack", 64'(ack_o), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.nm, "_rdata"}, 64'(rdata_o), 64'(e.rd));
                    chk({e.nm, "_err"},   64'(err_o),   64'(e.err));
                end
            end else begin
                chk("idle_rdata_err", 64'({rdata_o, err_o}), 64'd0);
            end
        end
    end

    int ack_before;

    initial begin
        rstn_i   = 1'b0;
        req_i    = 1'b0;
        wr_en_i  = 1'b0;
        addr_i   = '0;
        wdata_i  = '0;
        in_int_i = '0;
        idle(3);
        chk("rst_type",  64'(filter_type_o), 64'd0);
        chk("rst_win",   64'(window_size_o), 64'd0);
        chk("rst_wd",    64'(wd_rst_o),      64'd0);
        chk("rst_irq",   64'(irq_o),         64'd0);
        chk("rst_ack",   64'({ack_o, err_o, rdata_o}), 64'd0);
        rstn_i = 1'b1;
        idle(1);

        // Shadow write without commit leaves active outputs untouched
        acc(1'b1, 8'd2, 8'h4D, 8'h00, 1'b0, "wr_sh2");
        idle(1);
        chk("nocommit_type", 64'(filter_type_o), 64'd0);
        chk("nocommit_win",  64'(window_size_o), 64'd0);
        acc(1'b0, 8'd2, 8'h00, 8'h4D, 1'b0, "rd_sh2");

        // Commit: outputs visible the cycle after the commit edge
        acc(1'b1, 8'd18, 8'h01, 8'h00, 1'b0, "commit1");
        chk("commit_type", 64'(filter_type_o), 64'h0010);
        chk("commit_win",  64'(window_size_o), 64'h0000_0300);
        chk("commit_wd",   64'(wd_rst_o),      64'h00);
        acc(1'b0, 8'd18, 8'h00, 8'h00, 1'b0, "rd_gctrl");

        // Enable int on ch0, raise status, then W1C
        acc(1'b1, 8'd0,  8'h40, 8'h00, 1'b0, "wr_sh0");
        acc(1'b1, 8'd18, 8'h01, 8'h00, 1'b0, "commit2");
        pulse(0, 1);
        acc(1'b0, 8'd8,  8'h00, 8'h01, 1'b0, "rd_stat_set");
        chk("irq_set", 64'(irq_o), 64'd1);
        acc(1'b1, 8'd8,  8'h01, 8'h00, 1'b0, "w1c_stat");
        chk("irq_lag", 64'(irq_o), 64'd1);
        idle(1);
        chk("irq_clr", 64'(irq_o), 64'd0);
        acc(1'b0, 8'd8,  8'h00, 8'h00, 1'b0, "rd_stat_clr");

        // Set and W1C in the same cycle: set wins
        in_int_i[0] = 1'b1;
        acc(1'b1, 8'd8,  8'h01, 8'h00, 1'b0, "w1c_vs_set");
        in_int_i[0] = 1'b0;
        acc(1'b0, 8'd8,  8'h00, 8'h01, 1'b0, "rd_set_wins");
        chk("irq_set_wins", 64'(irq_o), 64'd1);

        // Mask hides the irq but not the status
        acc(1'b1, 8'd9,  8'h01, 8'h00, 1'b0, "wr_mask");
        idle(1);
        chk("irq_masked", 64'(irq_o), 64'd0);
        acc(1'b0, 8'd8,  8'h00, 8'h01, 1'b0, "rd_stat_masked");
        acc(1'b0, 8'd9,  8'h00, 8'h01, 1'b0, "rd_mask");
        acc(1'b1, 8'd8,  8'hFF, 8'h00, 1'b0, "w1c_all");

        // Counters: ch0 saw 2 events so far; ch3 saturates at 0x0F
        acc(1'b0, 8'd10, 8'h00, 8'h02, 1'b0, "rd_cnt0");
        pulse(3, 20);
        acc(1'b0, 8'd13, 8'h00, 8'h0F, 1'b0, "rd_cnt3_sat");
        acc(1'b0, 8'd13, 8'h00, 8'h00, 1'b0, "rd_cnt3_clr");
        pulse(3, 2);
        in_int_i[3] = 1'b1;
        acc(1'b0, 8'd13, 8'h00, 8'h02, 1'b0, "rd_cnt3_coinc");
        in_int_i[3] = 1'b0;
        acc(1'b0, 8'd13, 8'h00, 8'h01, 1'b0, "rd_cnt3_after");
        acc(1'b1, 8'd13, 8'h55, 8'h00, 1'b0, "wr_cnt_ignored");
        acc(1'b0, 8'd13, 8'h00, 8'h00, 1'b0, "rd_cnt3_zero");

        // CLR_ALL zeroes status and counters
        pulse(1, 3);
        pulse(0, 1);
        acc(1'b1, 8'd18, 8'h02, 8'h00, 1'b0, "clr_all");
        acc(1'b0, 8'd8,  8'h00, 8'h00, 1'b0, "rd_stat_clrall");
        acc(1'b0, 8'd11, 8'h00, 8'h00, 1'b0, "rd_cnt1_clrall");
        acc(1'b0, 8'd10, 8'h00, 8'h00, 1'b0, "rd_cnt0_clrall");

        // Out-of-range accesses
        acc(1'b0, 8'd19, 8'h00, 8'h00, 1'b1, "rd_oor");
        acc(1'b1, 8'd19, 8'hFF, 8'h00, 1'b1, "wr_oor");
        acc(1'b0, 8'd9,  8'h00, 8'h01, 1'b0, "rd_mask_after_oor");
        acc(1'b0, 8'd2,  8'h00, 8'h4D, 1'b0, "rd_sh2_after_oor");
        chk("type_after_oor", 64'(filter_type_o), 64'h0010);

        // Back-to-back reads: acks on consecutive cycles
        pulse(0, 1);
        ack_before = n_ack;
        acc(1'b0, 8'd0, 8'h00, 8'h40, 1'b0, "b2b_rd0");
        acc(1'b0, 8'd8, 8'h00, 8'h01, 1'b0, "b2b_rd8");
        @(negedge clk_i); #1;
        chk("b2b_ack_count", 64'(n_ack - ack_before), 64'd2);
        idle(1);
        chk("sb_empty_pre_rst", 64'(q.size()), 64'd0);

        // Reset in the middle of an access drops the pending ack and all state
        req_i   = 1'b1;
        wr_en_i = 1'b0;
        addr_i  = 8'd0;
        #2 rstn_i = 1'b0;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_ack",  64'(ack_o), 64'd0);
        chk("midrst_type", 64'(filter_type_o), 64'd0);
        chk("midrst_irq",  64'(irq_o), 64'd0);
        idle(2);
        rstn_i = 1'b1;
        idle(1);
        chk("post_rst_ack", 64'(ack_o), 64'd0);
        acc(1'b0, 8'd2, 8'h00, 8'h00, 1'b0, "rd_sh2_post_rst");
        acc(1'b0, 8'd9, 8'h00, 8'h00, 1'b0, "rd_mask_post_rst");
        idle(3);
        chk("sb_empty_end", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop guard in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
